// File: rtl/program_memory_system.sv
// program_memory_system: separate instruction/data RAMs filled by a boot
// loader port, a LOAD/RUN state machine, and a small MMIO block holding a
// prescaled COUNTER, an LFSR ENTROPY source and a free-running CYCLES count.
// Optional timer compare / interrupt logic is built only when the macro
// MMIO_TIMER_EN is defined; otherwise TIMER_CMP/TIMER_CTRL read as zero and
// irq_out stays low.

module program_memory_system #(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
  parameter int          PRESCALE    = 50,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_out,
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_write_enable_in,
  output logic [31:0] cpu_data_out,
  input  logic [31:0] brx_addr_in,
  input  logic [31:0] brx_data_in,
  input  logic        brx_valid_in,
  input  logic        brx_done_in,
  output logic        loaded_out,
  output logic        irq_out
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] MMIO_SPAN = 32'h0000_0014;
  localparam logic [31:0] SEED      = (LFSR_SEED == 32'h0000_0000) ? 32'h0000_0001 : LFSR_SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1, right-shifting form
  localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] RG_NONE = 2'd0;
  localparam logic [1:0] RG_DMEM = 2'd1;
  localparam logic [1:0] RG_MMIO = 2'd2;

  localparam logic [2:0] OFF_COUNTER = 3'd0;
  localparam logic [2:0] OFF_ENTROPY = 3'd1;
  localparam logic [2:0] OFF_CYCLES  = 3'd2;
  localparam logic [2:0] OFF_CMP     = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;

  // One step of the Galois LFSR; a non-zero state never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  logic [31:0] imem [DEPTH_WORDS];
  logic [31:0] dmem [DEPTH_WORDS];

  logic [AW-1:0] pc_idx;
  logic [AW-1:0] cpu_idx;
  logic [AW-1:0] brx_idx;
  logic [31:0]   imem_q;
  logic [31:0]   dmem_q;

  logic          state;
  logic          state_next;
  logic          brx_hit;
  logic          cpu_in_dmem;
  logic          cpu_in_mmio;
  logic          cpu_dmem_wr;
  logic          mmio_wr;
  logic [31:0]   mmio_off;
  logic [2:0]    mmio_sel;
  logic [1:0]    region;
  logic [1:0]    region_q;
  logic [2:0]    mmio_sel_q;
  logic [31:0]   mmio_rdata;

  logic [PW-1:0] pre;
  logic          tick;
  logic [31:0]   counter;
  logic [31:0]   counter_next;
  logic [31:0]   cycles;
  logic [31:0]   entropy;
  logic [31:0]   timer_cmp;
  logic          timer_en;
  logic          timer_pend;
  logic          unused_ok;

  assign pc_idx       = pc_in[AW+1:2];
  assign cpu_idx      = cpu_addr_in[AW+1:2];
  assign brx_idx      = brx_addr_in[AW+1:2];
  assign tick         = (pre == PRE_MAX);
  assign counter_next = counter + 32'd1;
  assign unused_ok    = &{1'b0, pc_in[31:AW+2], pc_in[1:0]};

  // Address decode and write qualification; the loader wins a same-word collision.
  always_comb begin
    brx_hit     = brx_valid_in && (brx_addr_in < MEM_BYTES);
    cpu_in_dmem = (cpu_addr_in < MEM_BYTES);
    mmio_off    = cpu_addr_in - MMIO_BASE;
    cpu_in_mmio = (cpu_addr_in >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
    mmio_sel    = mmio_off[4:2];
    cpu_dmem_wr = (state == ST_RUN) && cpu_in_dmem && (cpu_write_enable_in != 4'b0000)
                  && !(brx_hit && (brx_idx == cpu_idx));
    mmio_wr     = cpu_in_mmio && (cpu_write_enable_in == 4'b1111);
    if (cpu_in_dmem) begin
      region = RG_DMEM;
    end else if (cpu_in_mmio) begin
      region = RG_MMIO;
    end else begin
      region = RG_NONE;
    end
  end

  // Next-state logic: LOAD leaves on the done pulse, RUN holds until reset.
  always_comb begin
    case (state)
      ST_LOAD: begin
        if (brx_done_in) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_LOAD;
    endcase
  end

  // State register with a registered copy driving loaded_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_LOAD;
      loaded_out <= 1'b0;
    end else begin
      state      <= state_next;
      loaded_out <= (state_next == ST_RUN);
    end
  end

  // Instruction RAM: loader-only writes, registered read (contents survive reset).
  always_ff @(posedge clk_in) begin
    imem_q <= imem[pc_idx];
    if (brx_hit) begin
      imem[brx_idx] <= brx_data_in;
    end
  end

  // Data RAM: CPU byte writes plus loader word writes, registered read.
  always_ff @(posedge clk_in) begin
    dmem_q <= dmem[cpu_idx];
    if (cpu_dmem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_write_enable_in[b]) begin
          dmem[cpu_idx][8*b +: 8] <= cpu_data_in[8*b +: 8];
        end
      end
    end
    if (brx_hit) begin
      dmem[brx_idx] <= brx_data_in;
    end
  end

  // Prescaler and COUNTER; COUNTER wraps naturally at 32 bits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre     <= '0;
      counter <= 32'h0000_0000;
    end else if (tick) begin
      pre     <= '0;
      counter <= counter_next;
    end else begin
      pre     <= pre + PW'(1);
    end
  end

  // Free-running cycle count and entropy LFSR.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cycles  <= 32'h0000_0000;
      entropy <= SEED;
    end else begin
      cycles  <= cycles + 32'd1;
      entropy <= lfsr_step(entropy);
    end
  end

`ifdef MMIO_TIMER_EN
  logic pend_set;
  logic pend_clr;

  assign pend_set = timer_en && tick && (counter_next == timer_cmp);
  assign pend_clr = mmio_wr && (mmio_sel == OFF_CTRL) && cpu_data_in[1];

  // Timer compare/control registers; a new match beats a same-cycle W1C.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer_cmp  <= 32'h0000_0000;
      timer_en   <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      if (mmio_wr && (mmio_sel == OFF_CMP)) begin
        timer_cmp <= cpu_data_in;
      end
      if (mmio_wr && (mmio_sel == OFF_CTRL)) begin
        timer_en <= cpu_data_in[0];
      end
      if (pend_set) begin
        timer_pend <= 1'b1;
      end else if (pend_clr) begin
        timer_pend <= 1'b0;
      end
    end
  end
`else
  logic unused_timer;

  assign timer_cmp    = 32'h0000_0000;
  assign timer_en     = 1'b0;
  assign timer_pend   = 1'b0;
  assign unused_timer = mmio_wr;
`endif

  // Registered interrupt, only asserted once the program is loaded.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      irq_out <= 1'b0;
    end else begin
      irq_out <= timer_pend & timer_en & (state == ST_RUN);
    end
  end

  // MMIO read mux, evaluated in the cycle after the address was sampled.
  always_comb begin
    case (mmio_sel_q)
      OFF_COUNTER: mmio_rdata = counter;
      OFF_ENTROPY: mmio_rdata = entropy;
      OFF_CYCLES:  mmio_rdata = cycles;
      OFF_CMP:     mmio_rdata = timer_cmp;
      OFF_CTRL:    mmio_rdata = {30'h0000_0000, timer_pend, timer_en};
      default:     mmio_rdata = 32'h0000_0000;
    endcase
  end

  // Region select travels alongside the RAM read so all regions share latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      region_q   <= RG_NONE;
      mmio_sel_q <= 3'd0;
    end else begin
      region_q   <= region;
      mmio_sel_q <= mmio_sel;
    end
  end

  // Second pipeline stage: registered instruction and data outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      instr_out    <= 32'h0000_0000;
      cpu_data_out <= 32'h0000_0000;
    end else begin
      instr_out <= imem_q;
      case (region_q)
        RG_DMEM: cpu_data_out <= dmem_q;
        RG_MMIO: cpu_data_out <= mmio_rdata;
        default: cpu_data_out <= 32'h0000_0000;
      endcase
    end
  end

endmodule
